// File: rtl/gates_reduce_pkg.sv
// Shared types and sizing helpers for the chunked gate-reduction block.
package gates_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_nchunk(input int data_w, input int chunk_w);
    return (data_w + chunk_w - 1) / chunk_w;
  endfunction

  function automatic int calc_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/chunk_reduce.sv
// Combinational AND/OR/XOR/popcount of one chunk; masked-off bits are neutral.
module chunk_reduce #(
  parameter int CHUNK_W = 25,
  localparam int PC_W = $clog2(CHUNK_W + 1)
) (
  input  logic [CHUNK_W-1:0] bits_i,
  input  logic [CHUNK_W-1:0] mask_i,
  output logic               and_o,
  output logic               or_o,
  output logic               xor_o,
  output logic [PC_W-1:0]    pop_o
);

  logic [CHUNK_W-1:0] valid_s;

  assign valid_s = bits_i & mask_i;
  // Padding positions read as 1 for AND and as 0 for everything else.
  assign and_o   = &(bits_i | ~mask_i);
  assign or_o    = |valid_s;
  assign xor_o   = ^valid_s;

  // Population count of the unmasked bits.
  always_comb begin
    pop_o = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      pop_o = pop_o + PC_W'(valid_s[i]);
    end
  end

endmodule

// File: rtl/gates_reduce_seq.sv
// Sequential reduction of a wide vector, CHUNK_W bits per cycle, with
// valid/ready handshakes on both sides.
module gates_reduce_seq
  import gates_reduce_pkg::*;
#(
  parameter int DATA_W  = 100,
  parameter int CHUNK_W = 25,
  localparam int CNT_W  = calc_cnt_w(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_and,
  output logic              out_or,
  output logic              out_xor,
  output logic [CNT_W-1:0]  out_cnt
);

  localparam int NCHUNK = calc_nchunk(DATA_W, CHUNK_W);
  localparam int PAD_W  = NCHUNK * CHUNK_W;
  localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PC_W   = $clog2(CHUNK_W + 1);

  state_e             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic               acc_and_q, acc_and_d, acc_or_q, acc_or_d, acc_xor_q, acc_xor_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic               out_and_q, out_and_d, out_or_q, out_or_d, out_xor_q, out_xor_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;

  logic [PAD_W-1:0]   din_pad_s, mask_pad_s;
  logic [CHUNK_W-1:0] chunk_bits_s, chunk_mask_s;
  logic               c_and_s, c_or_s, c_xor_s;
  logic [PC_W-1:0]    c_pop_s;
  logic               fold_and_s, fold_or_s, fold_xor_s;
  logic [CNT_W-1:0]   fold_cnt_s;

  // Zero-extend to a whole number of chunks; the mask marks real bit positions.
  assign din_pad_s    = PAD_W'(din_q);
  assign mask_pad_s   = PAD_W'({DATA_W{1'b1}});
  assign chunk_bits_s = CHUNK_W'(din_pad_s >> (k_q * CHUNK_W));
  assign chunk_mask_s = CHUNK_W'(mask_pad_s >> (k_q * CHUNK_W));

  chunk_reduce #(.CHUNK_W(CHUNK_W)) u_chunk (
    .bits_i (chunk_bits_s),
    .mask_i (chunk_mask_s),
    .and_o  (c_and_s),
    .or_o   (c_or_s),
    .xor_o  (c_xor_s),
    .pop_o  (c_pop_s)
  );

  assign fold_and_s = acc_and_q & c_and_s;
  assign fold_or_s  = acc_or_q | c_or_s;
  assign fold_xor_s = acc_xor_q ^ c_xor_s;
  assign fold_cnt_s = acc_cnt_q + CNT_W'(c_pop_s);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_and   = out_and_q;
  assign out_or    = out_or_q;
  assign out_xor   = out_xor_q;
  assign out_cnt   = out_cnt_q;

  // Next-state, chunk index, accumulator and result register updates.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    din_d     = din_q;
    acc_and_d = acc_and_q;
    acc_or_d  = acc_or_q;
    acc_xor_d = acc_xor_q;
    acc_cnt_d = acc_cnt_q;
    out_and_d = out_and_q;
    out_or_d  = out_or_q;
    out_xor_d = out_xor_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          din_d     = din;
          k_d       = '0;
          acc_and_d = 1'b1;
          acc_or_d  = 1'b0;
          acc_xor_d = 1'b0;
          acc_cnt_d = '0;
          state_d   = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        acc_and_d = fold_and_s;
        acc_or_d  = fold_or_s;
        acc_xor_d = fold_xor_s;
        acc_cnt_d = fold_cnt_s;
        if (k_q == K_W'(NCHUNK - 1)) begin
          k_d       = '0;
          out_and_d = fold_and_s;
          out_or_d  = fold_or_s;
          out_xor_d = fold_xor_s;
          out_cnt_d = fold_cnt_s;
          state_d   = DONE;
        end else begin
          k_d = k_q + K_W'(1'b1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any job and clears results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      din_q     <= '0;
      acc_and_q <= 1'b0;
      acc_or_q  <= 1'b0;
      acc_xor_q <= 1'b0;
      acc_cnt_q <= '0;
      out_and_q <= 1'b0;
      out_or_q  <= 1'b0;
      out_xor_q <= 1'b0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      din_q     <= din_d;
      acc_and_q <= acc_and_d;
      acc_or_q  <= acc_or_d;
      acc_xor_q <= acc_xor_d;
      acc_cnt_q <= acc_cnt_d;
      out_and_q <= out_and_d;
      out_or_q  <= out_or_d;
      out_xor_q <= out_xor_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_gates_reduce_seq.sv
// Self-checking bench: directed cases plus a random sweep against a bit-count model.
module tb_gates_reduce_seq;

  localparam int DW = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] din;
  logic          out_and, out_or, out_xor;
  logic [6:0]    out_cnt;
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0] b_din;
  logic          b_out_and, b_out_or, b_out_xor;
  logic [6:0]    b_out_cnt;
  logic [9:0]    obs_a, obs_b;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign obs_a = {out_and, out_or, out_xor, out_cnt};
  assign obs_b = {b_out_and, b_out_or, b_out_xor, b_out_cnt};

  gates_reduce_seq #(.DATA_W(DW), .CHUNK_W(25)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .out_and(out_and), .out_or(out_or),
    .out_xor(out_xor), .out_cnt(out_cnt)
  );

  gates_reduce_seq #(.DATA_W(DW), .CHUNK_W(30)) dut30 (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .din(b_din),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_and(b_out_and), .out_or(b_out_or),
    .out_xor(b_out_xor), .out_cnt(b_out_cnt)
  );

  // Golden result {and, or, xor, cnt} from the number of set bits.
  function automatic logic [9:0] golden(input logic [DW-1:0] v);
    int c;
    logic [9:0] r;
    c = 0;
    for (int i = 0; i < DW; i++) if (v[i]) c++;
    r[9]   = (c == DW);
    r[8]   = (c != 0);
    r[7]   = c[0];
    r[6:0] = 7'(c);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic accept_a(input logic [DW-1:0] v);
    @(negedge clk); din = v; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0; din = rand_vec();
  endtask

  task automatic wait_done_a(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      din = rand_vec();
      @(negedge clk); n++;
    end
  endtask

  task automatic consume_a();
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic run_b(input logic [DW-1:0] v, output int n);
    @(negedge clk); b_din = v; b_in_valid = 1'b1;
    @(negedge clk); b_in_valid = 1'b0; b_din = '0;
    n = 0;
    while (b_out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1 || b_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b/%b want 1", in_ready, b_in_ready); end
    checks++; if (out_valid !== 1'b0 || b_out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b/%b want 0", out_valid, b_out_valid); end
    checks++; if (obs_a !== 10'h000 || obs_b !== 10'h000) begin fails++; $display("FAIL reset_outputs got %h/%h want 000", obs_a, obs_b); end
  endtask

  task automatic test_zero();
    int n;
    accept_a('0); wait_done_a(n);
    checks++; if (n !== 4) begin fails++; $display("FAIL zero_latency got %0d want 4", n); end
    checks++; if (obs_a !== {3'b000, 7'd0}) begin fails++; $display("FAIL zero_result got %h want %h", obs_a, {3'b000, 7'd0}); end
    consume_a();
  endtask

  task automatic test_ones();
    int n;
    accept_a({DW{1'b1}}); wait_done_a(n);
    checks++; if (n !== 4) begin fails++; $display("FAIL ones_latency got %0d want 4", n); end
    checks++; if (obs_a !== {3'b110, 7'd100}) begin fails++; $display("FAIL ones_result got %h want %h", obs_a, {3'b110, 7'd100}); end
    consume_a();
  endtask

  task automatic test_padded_chunk();
    int n;
    logic [DW-1:0] v;
    v = '0; v[DW-1] = 1'b1;
    run_b(v, n);
    checks++; if (n !== 4) begin fails++; $display("FAIL pad_latency got %0d want 4", n); end
    checks++; if (obs_b !== {3'b011, 7'd1}) begin fails++; $display("FAIL pad_msb got %h want %h", obs_b, {3'b011, 7'd1}); end
    b_out_ready = 1'b1; @(negedge clk); b_out_ready = 1'b0;
    run_b(~v, n);
    checks++; if (obs_b !== {3'b011, 7'd99}) begin fails++; $display("FAIL pad_inv got %h want %h", obs_b, {3'b011, 7'd99}); end
    b_out_ready = 1'b1; @(negedge clk); b_out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    logic [DW-1:0] v;
    logic [9:0] exp;
    v = rand_vec(); exp = golden(v);
    accept_a(v); wait_done_a(n);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; din = rand_vec(); out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs_a !== exp) begin
        fails++; $display("FAIL bp_hold cyc %0d got v=%b r=%b res=%h want 1 0 %h", i, out_valid, in_ready, obs_a, exp);
      end
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || obs_a !== exp) begin
      fails++; $display("FAIL bp_release got r=%b v=%b res=%h want 1 0 %h", in_ready, out_valid, obs_a, exp);
    end
    accept_a(DW'(5)); wait_done_a(n);
    checks++; if (n !== 4 || obs_a !== {3'b010, 7'd2}) begin fails++; $display("FAIL bp_next got lat=%0d res=%h want 4 %h", n, obs_a, {3'b010, 7'd2}); end
    consume_a();
  endtask

  task automatic test_reset_mid_busy();
    int n;
    logic seen;
    accept_a({DW{1'b1}});
    @(negedge clk); @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || obs_a !== 10'h000) begin
      fails++; $display("FAIL rst_busy_now got r=%b v=%b res=%h want 1 0 000", in_ready, out_valid, obs_a);
    end
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (out_valid !== 1'b0 || obs_a !== 10'h000) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_busy_abort got result activity=%b want 0", seen); end
    accept_a(DW'(7)); wait_done_a(n);
    checks++; if (n !== 4 || obs_a !== {3'b011, 7'd3}) begin fails++; $display("FAIL rst_busy_next got lat=%0d res=%h want 4 %h", n, obs_a, {3'b011, 7'd3}); end
    consume_a();
  endtask

  task automatic test_random_sweep();
    int n;
    int stall;
    logic [DW-1:0] v;
    logic [9:0] exp;
    for (int j = 0; j < 200; j++) begin
      case ($urandom_range(0, 7))
        0: v = {DW{1'b1}};
        1: v = ~(DW'(1) << $urandom_range(0, DW - 1));
        2: v = DW'(1) << $urandom_range(0, DW - 1);
        default: v = rand_vec();
      endcase
      exp = golden(v);
      accept_a(v); wait_done_a(n);
      checks++; if (n !== 4) begin fails++; $display("FAIL rand_latency job %0d got %0d want 4", j, n); end
      checks++; if (obs_a !== exp) begin fails++; $display("FAIL rand_result job %0d got %h want %h", j, obs_a, exp); end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || obs_a !== exp) begin fails++; $display("FAIL rand_stall job %0d got v=%b res=%h want 1 %h", j, out_valid, obs_a, exp); end
      end
      consume_a();
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; din = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_din = '0;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_zero();
    test_ones();
    test_padded_chunk();
    test_backpressure();
    test_reset_mid_busy();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/gates_reduce_seq.md
GATES_REDUCE_SEQ -- requirements
Module: gates_reduce_seq

Interface
REQ-001 Parameter DATA_W, default 100: width of the input vector; legal range 1 to 1024.
REQ-002 Parameter CHUNK_W, default 25: bits reduced per cycle; legal range 1 to DATA_W.
REQ-003 Derived constants: NCHUNK = ceil(DATA_W/CHUNK_W); CNT_W = clog2(DATA_W+1).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  din is presented for capture.
REQ-007 in_ready  output  1  block accepts a vector this cycle.
REQ-008 din  input  DATA_W  vector to reduce.
REQ-009 out_valid  output  1  result outputs are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_and  output  1  AND of all DATA_W bits.
REQ-012 out_or  output  1  OR of all DATA_W bits.
REQ-013 out_xor  output  1  XOR (parity) of all DATA_W bits.
REQ-014 out_cnt  output  CNT_W  number of set bits in the vector.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE, decoded combinationally from the state.
REQ-017 On the edge where in_valid and in_ready are both 1, the block SHALL:
  - register din;
  - clear chunk index k to 0;
  - initialise accumulators: and=1, or=0, xor=0, cnt=0;
  - enter BUSY.
REQ-018 Each BUSY cycle SHALL fold bits [k*CHUNK_W +: CHUNK_W] into the accumulators, then increment k.
REQ-019 In the last chunk, bit positions at or above DATA_W SHALL be masked: AND treats them as 1; OR, XOR and count treat them as 0.
REQ-020 The edge that folds chunk NCHUNK-1 SHALL move the FSM to DONE.
  - out_valid rises exactly NCHUNK edges after the accept edge.
REQ-021 out_valid SHALL be 1 only in DONE.
REQ-022 out_and, out_or, out_xor and out_cnt SHALL hold stable from entry into DONE until the handshake completes.
REQ-023 In DONE, out_valid and out_ready both 1 SHALL return the FSM to IDLE on that edge.
  - The result outputs keep their values in IDLE until the next accept.
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 in_valid SHALL be ignored outside IDLE.
  - A vector cannot be accepted on the same edge a result is consumed.
  - Throughput is one vector per NCHUNK+2 cycles at best.
REQ-026 When CHUNK_W = DATA_W, NCHUNK = 1: the FSM SHALL spend exactly one cycle in BUSY.
REQ-027 out_cnt SHALL count exactly, with no overflow; its maximum value is DATA_W.
REQ-028 The registered din copy SHALL be the only source of reduction data; later changes on din do not affect a job in flight.

Reset
REQ-029 Asserting reset SHALL immediately force:
  - state to IDLE and k to 0;
  - out_valid = 0, in_ready = 1;
  - out_and = out_or = out_xor = 0 and out_cnt = 0.
REQ-030 Reset asserted during BUSY or DONE SHALL abort the job with no result produced.
  - The first accept after deassertion starts from freshly initialised accumulators.

Structure
REQ-031 A shared package gates_reduce_pkg SHALL hold:
  - the state enum {IDLE, BUSY, DONE};
  - the NCHUNK and CNT_W calculation functions.
REQ-032 Per-chunk reduction SHALL live in one combinational sub-module, chunk_reduce.
  - Parameter: CHUNK_W.
  - Inputs: chunk bits and valid-bit mask.
  - Outputs: chunk and, or, xor and popcount.
REQ-033 gates_reduce_seq SHALL contain only the FSM, chunk index, input register, accumulators and output registers.

Verification
REQ-034 DATA_W=100, CHUNK_W=25, din=0 -> out_valid after 4 edges; and=0, or=0, xor=0, cnt=0.
REQ-035 DATA_W=100, CHUNK_W=25, din=all ones -> and=1, or=1, xor=0, cnt=100.
REQ-036 DATA_W=100, CHUNK_W=30, din=1<<99 (bit in padded last chunk) -> and=0, or=1, xor=1, cnt=1.
  - Repeat with din=~(1<<99) -> and=0, or=1, xor=1, cnt=99.
REQ-037 Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is ignored.
  - Then out_ready=1 for one cycle -> IDLE; the next accept succeeds.
REQ-038 Reset mid-BUSY (after 2 chunks of din=all ones) -> out_valid never rises and outputs are 0.
  - A following job with din=0x7 returns and=0, or=1, xor=1, cnt=3.
REQ-039 A random sweep of 200 vectors against a combinational golden reduction, with random out_ready stalls, SHALL produce zero mismatches.
